// File: rtl/maxpool_2x2.sv
// maxpool_2x2
//   Streaming 2x2 / stride-2 max-pooling stage. Consumes a raster-ordered
//   IN_DIM x IN_DIM signed pixel stream (one pixel per valid beat) and emits
//   the (IN_DIM/2) x (IN_DIM/2) pooled map in raster order. Only a half-width
//   line buffer of horizontal pair maxima is kept. Odd IN_DIM floors: the
//   last column and last row are counted but discarded.
//
//   Optional feature macro: MAXPOOL_RELU_EN -- when defined, negative input
//   pixels are clamped to zero before comparison.
//
// Ports
//   clk_i         in   1         clock, rising edge
//   rst_i         in   1         asynchronous active-high reset
//   pixel_i       in   DATA_RES  signed input pixel
//   data_valid_i  in   1         input beat qualifier (no back-pressure)
//   pixel_o       out  DATA_RES  pooled pixel, registered, held between emits
//   data_valid_o  out  1         one-cycle pulse per pooled pixel
//   frame_done_o  out  1         pulse with the last pooled pixel of a frame
module maxpool_2x2 #(
    parameter int DATA_RES = 8,
    parameter int IN_DIM   = 26
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATA_RES-1:0] pixel_i,
    input  logic                data_valid_i,
    output logic [DATA_RES-1:0] pixel_o,
    output logic                data_valid_o,
    output logic                frame_done_o
);

    localparam int POOL = IN_DIM / 2;
    localparam int CW   = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int IW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_DIM - 1);
    localparam logic [CW-1:0] ACT_LAST = CW'(2 * POOL - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0]       col_q, col_d, row_q, row_d;
    logic [DATA_RES-1:0] hold_q, hold_d, pix_q, pix_d;
    logic                dv_q, dv_d, fd_q, fd_d;
    logic [DATA_RES-1:0] line_buf_q [POOL];

    logic                buf_we;
    logic [IW-1:0]       buf_idx;
    logic [DATA_RES-1:0] p, pair_max;

    function automatic logic [DATA_RES-1:0] smax(input logic [DATA_RES-1:0] a,
                                                  input logic [DATA_RES-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

`ifdef MAXPOOL_RELU_EN
    assign p = pixel_i[DATA_RES-1] ? '0 : pixel_i;
`else
    assign p = pixel_i;
`endif

    // Each line buffer entry covers one output column (two input columns).
    assign buf_idx  = IW'(col_q >> 1);
    assign pair_max = smax(hold_q, p);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        pix_d  = pix_q;
        dv_d   = 1'b0;
        fd_d   = 1'b0;
        buf_we = 1'b0;
        if (data_valid_i) begin
            if (col_q == IN_LAST) begin
                col_d = '0;
                row_d = (row_q == IN_LAST) ? '0 : row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
            if (col_q <= ACT_LAST && row_q <= ACT_LAST) begin
                // Phase from coordinate parity: even col = HOLD,
                // odd col/even row = STORE, odd col/odd row = EMIT.
                case ({row_q[0], col_q[0]})
                    2'b00, 2'b10: hold_d = p;
                    2'b01:        buf_we = 1'b1;
                    default: begin
                        pix_d = smax(line_buf_q[buf_idx], pair_max);
                        dv_d  = 1'b1;
                        fd_d  = (row_q == ACT_LAST) && (col_q == ACT_LAST);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q  <= '0;
            row_q  <= '0;
            hold_q <= '0;
            pix_q  <= '0;
            dv_q   <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            hold_q <= hold_d;
            pix_q  <= pix_d;
            dv_q   <= dv_d;
            fd_q   <= fd_d;
        end
    end

    // Not reset: every entry is written on an even row before the odd row
    // reads it.
    always_ff @(posedge clk_i) begin
        if (buf_we) line_buf_q[buf_idx] <= pair_max;
    end

    assign pixel_o      = pix_q;
    assign data_valid_o = dv_q;
    assign frame_done_o = fd_q;

endmodule
